mac_operand_seq: RTL and testbench

Operand sequencer that feeds the gated-clock multiply-accumulate stage. It buffers an incoming stream of 8-bit operand pairs in a small FIFO and issues one pair per enabled cycle on `mac_A`/`mac_B`/`mac_en`. It frames each dot-product with a single-cycle `mac_clr` and signals `done` once the accumulator result has settled. All MAC-facing outputs are registered and hold their value when idle, which keeps toggling low in the gated domain.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_opnd_fifo.sv | 47 ++++
 rtl/mac_operand_seq.sv | 114 +++++++++++
 tb/tb_mac_operand_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC-side blocks: operand width, sequencer states, operand pair.
package mac_pkg;

  localparam int unsigned OPND_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } mac_seq_state_t;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } opnd_pair_t;

endpackage

// File: rtl/mac_opnd_fifo.sv
// Synchronous operand-pair FIFO, DEPTH entries (power of two), no write-to-read bypass.
module mac_opnd_fifo
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  opnd_pair_t din,
  input  logic       pop,
  output opnd_pair_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  opnd_pair_t     mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_operand_seq.sv
// Operand sequencer feeding the gated-clock MAC; buffers pairs and frames each dot-product.
// Optional stall counter output enabled by MAC_OPERAND_SEQ_STALL_CNT_EN.
module mac_operand_seq
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ACC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [OPND_W-1:0] in_A,
  input  logic [OPND_W-1:0] in_B,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [OPND_W-1:0] mac_A,
  output logic [OPND_W-1:0] mac_B,
  output logic              busy,
  output logic              done
`ifdef MAC_OPERAND_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(ACC_LAT - 1);

  mac_seq_state_t    state;
  mac_seq_state_t    state_d;
  logic [LEN_W-1:0]  count;
  logic [DW-1:0]     drain_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  opnd_pair_t        in_pair;
  opnd_pair_t        head;

  assign in_pair = '{a: in_A, b: in_B};
  assign in_rdy  = ~fifo_full;

  mac_opnd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_vld),
    .din   (in_pair),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = (count != '0) ? RUN : DRAIN;
      RUN: begin
        if (!fifo_empty && count != '0) begin
          pop = 1'b1;
          if (count == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: if (drain_cnt == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MAC-facing outputs are registered from the next state so they settle with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      drain_cnt <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_A     <= '0;
      mac_B     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_d;
      mac_clr <= (state_d == CLEAR);
      mac_en  <= pop;
      busy    <= (state_d != IDLE);
      done    <= (state == DONE);
      if (pop) begin
        mac_A <= head.a;
        mac_B <= head.b;
      end
      if (state == IDLE && start) count <= len;
      else if (pop)               count <= count - LEN_W'(1);
      if (state_d == DRAIN && state != DRAIN)  drain_cnt <= DRAIN_INIT;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
    end
  end

`ifdef MAC_OPERAND_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                      stall_cnt <= '0;
    else if (state == IDLE && start)                 stall_cnt <= '0;
    else if (state == RUN && fifo_empty && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mac_operand_seq.sv
// Directed self-checking bench for mac_operand_seq (DEPTH=4, ACC_LAT=2).
module tb_mac_operand_seq;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned ACC_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [7:0]       in_A = '0;
  logic [7:0]       in_B = '0;
  logic             mac_clr;
  logic             mac_en;
  logic [7:0]       mac_A;
  logic [7:0]       mac_B;
  logic             busy;
  logic             done;
`ifdef MAC_OPERAND_SEQ_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  mac_operand_seq #(
    .DEPTH   (DEPTH),
    .LEN_W   (LEN_W),
    .ACC_LAT (ACC_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_A    (in_A),
    .in_B    (in_B),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .mac_A   (mac_A),
    .mac_B   (mac_B),
    .busy    (busy),
    .done    (done)
`ifdef MAC_OPERAND_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_err = 0;

  logic [15:0] got[$];
  int          en_cyc[$];
  int          clr_cnt = 0;
  int          clr_cyc = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          overlap = 0;
  int          hold_err = 0;
  logic        busy_at_done = 1'b1;
  logic [15:0] prev_ab = '0;
  int          s;

  always @(negedge clk) begin
    if (mac_en) begin
      got.push_back({mac_A, mac_B});
      en_cyc.push_back(cyc);
    end else if ({mac_A, mac_B} !== prev_ab) begin
      hold_err++;
    end
    if (mac_clr) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (mac_clr && mac_en) overlap++;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    prev_ab = {mac_A, mac_B};
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic clear_log();
    got.delete();
    en_cyc.delete();
    clr_cnt  = 0;
    hold_err = 0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    bit acc = 1'b0;
    in_A   = a;
    in_B   = b;
    in_vld = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = in_rdy;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    check("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    s     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    for (int i = 0; i < 300 && done_cnt < exp_cnt; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("done_seen", 32'(done_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mac_clr", 32'(mac_clr), 32'd0);
    check("rst_mac_en",  32'(mac_en), 32'd0);
    check("rst_mac_ab",  32'({mac_A, mac_B}), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_in_rdy",  32'(in_rdy), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic vector, len changed after start must not matter
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    push(8'd1, 8'd7);
    clear_log();
    do_start(8'd3);
    len = 8'd9;
    wait_done(1);
    check("basic_clr_cnt", 32'(clr_cnt), 32'd1);
    check("basic_clr_cyc", 32'(clr_cyc), 32'(s + 1));
    check("basic_n_pairs", 32'(got.size()), 32'd3);
    check("basic_p0", 32'(got[0]), 32'h0203);
    check("basic_p1", 32'(got[1]), 32'h0405);
    check("basic_p2", 32'(got[2]), 32'h0107);
    check("basic_en0_cyc", 32'(en_cyc[0]), 32'(s + 3));
    check("basic_en2_cyc", 32'(en_cyc[2]), 32'(s + 5));
    check("basic_done_cyc", 32'(done_cyc), 32'(s + 8));
    check("basic_busy_at_done", 32'(busy_at_done), 32'd0);
    check("basic_busy_after", 32'(busy), 32'd0);
    check("basic_hold", 32'(hold_err), 32'd0);

    // Zero length leaves the FIFO untouched
    push(8'h55, 8'h66);
    clear_log();
    do_start(8'd0);
    wait_done(2);
    check("zero_clr_cyc", 32'(clr_cyc), 32'(s + 1));
    check("zero_n_pairs", 32'(got.size()), 32'd0);
    check("zero_done_cyc", 32'(done_cyc), 32'(s + 3 + ACC_LAT));
    clear_log();
    do_start(8'd1);
    wait_done(3);
    check("zero_kept_pair", 32'(got[0]), 32'h5566);
    check("zero_kept_done", 32'(done_cyc), 32'(s + 1 + ACC_LAT + 3));

    // Backpressure: 4 fill the FIFO, the rest follow once it drains
    for (int i = 0; i < 4; i++) push(8'(i + 1), 8'(8'h10 + i));
    check("bp_full_rdy", 32'(in_rdy), 32'd0);
    in_vld = 1'b1;
    in_A   = 8'hEE;
    in_B   = 8'hEE;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    check("bp_still_full", 32'(in_rdy), 32'd0);
    clear_log();
    do_start(8'd6);
    push(8'd5, 8'h14);
    push(8'd6, 8'h15);
    wait_done(4);
    check("bp_n_pairs", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check("bp_pair", 32'(got[i]), 32'({8'(i + 1), 8'(8'h10 + i)}));
    check("bp_en_span", 32'(en_cyc[5] - en_cyc[0]), 32'd5);
    check("bp_done_cyc", 32'(done_cyc), 32'(s + 6 + ACC_LAT + 3));

    // Input stall: one pair every 3 cycles
    clear_log();
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      push(8'(8'hA0 + i), 8'(8'hB0 + i));
      if (i != 3) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    wait_done(5);
    check("stall_n_pairs", 32'(got.size()), 32'd4);
    check("stall_p3", 32'(got[3]), 32'hA3B3);
    check("stall_en0_cyc", 32'(en_cyc[0]), 32'(s + 3));
    for (int i = 1; i < 4; i++)
      check("stall_en_gap", 32'(en_cyc[i] - en_cyc[i-1]), 32'd3);
    check("stall_hold", 32'(hold_err), 32'd0);
    check("stall_done_cyc", 32'(done_cyc), 32'(en_cyc[3] + ACC_LAT + 1));
`ifdef MAC_OPERAND_SEQ_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'd6);
`endif

    // Second start while busy is ignored
    push(8'h21, 8'h22);
    push(8'h23, 8'h24);
    clear_log();
    do_start(8'd2);
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6);
    check("ign_clr_cnt", 32'(clr_cnt), 32'd1);
    check("ign_n_pairs", 32'(got.size()), 32'd2);
    check("ign_p1", 32'(got[1]), 32'h2324);
    check("ign_done_cyc", 32'(done_cyc), 32'(s + 2 + ACC_LAT + 3));

    // Reset after 2 of 5 pairs
    for (int i = 0; i < 4; i++) push(8'(8'h31 + i), 8'h40);
    clear_log();
    do_start(8'd5);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_outs", 32'({mac_clr, mac_en, busy, done}), 32'd0);
    check("mid_rst_ab", 32'({mac_A, mac_B}), 32'd0);
    check("mid_rst_rdy", 32'(in_rdy), 32'd1);
    rst_n = 1'b1;
    base  = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_pairs", 32'(got.size()), 32'd2);
    check("mid_rst_no_done", 32'(done_cnt), 32'(base));
    clear_log();
    do_start(8'd1);
    push(8'h77, 8'h78);
    wait_done(base + 1);
    check("post_rst_pair", 32'(got[0]), 32'h7778);
    check("post_rst_n", 32'(got.size()), 32'd1);
    check("post_rst_done", 32'(done_cyc), 32'(s + 6));

    check("clr_en_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
